// File: rtl/vppm_rx_pkg.sv
// Shared types and constants for the VPPM receive sequencer.
// Build option VPPM_RESYNC_EN enables edge-driven phase realignment.
package vppm_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FREQ,
    HUNT,
    SYNC,
    SAMPLE,
    ERR
  } state_t;

  localparam int CNT_W_DEF  = 25;
  localparam int MIN_PERIOD = 4;

endpackage

// File: rtl/vppm_phase_timer.sv
// Symbol phase counter, quarter-period sample strobe and signal-loss timer.
// With VPPM_RESYNC_EN defined, edges near a symbol boundary realign phase.
module vppm_phase_timer
  import vppm_rx_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int TIMEOUT_SYMBOLS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] per_q,
  input  logic             edge_det,
  input  logic             start,
  input  logic             run,
  input  logic             tmr_en,
  output logic             sample,
  output logic             timeout
);

  localparam int TW = CNT_W + 4;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [TW-1:0]    TONE = TW'(1);

  logic [CNT_W-1:0] phase;
  logic [TW-1:0]    tmr;
  logic [TW-1:0]    lim;
  logic             resync;

  assign lim     = TW'(TIMEOUT_SYMBOLS) * {4'd0, per_q};
  assign sample  = run && (phase == (per_q >> 2));
  assign timeout = tmr_en && !edge_det && (tmr == lim);

`ifdef VPPM_RESYNC_EN
  logic [CNT_W-1:0] win;
  assign win    = per_q >> 3;
  // Window lies outside the sample point, so realignment never repeats a strobe.
  assign resync = run && edge_det &&
                  ((phase > per_q - win) || (phase < win));
`else
  assign resync = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      tmr   <= '0;
    end else begin
      if (start || !run || resync)
        phase <= '0;
      else if (phase == per_q - ONE)
        phase <= '0;
      else
        phase <= phase + ONE;

      if (!tmr_en || edge_det)
        tmr <= '0;
      else if (tmr != lim)
        tmr <= tmr + TONE;
    end
  end

endmodule

// File: rtl/vppm_rx_controller.sv
// VPPM receive sequencer: preamble hunt, bit sampling, byte handshake.
// Optional build macro VPPM_RESYNC_EN (see vppm_phase_timer).
module vppm_rx_controller
  import vppm_rx_pkg::*;
#(
  parameter int PREAMBLE_EDGES  = 7,
  parameter int FRAME_BYTES     = 4,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int TIMEOUT_SYMBOLS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        vppm_in,
  input  logic        freq_valid,
  input  logic [31:0] period_cycles,
  output logic        sample_point,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int EW = $clog2(PREAMBLE_EDGES + 1);
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(PREAMBLE_EDGES - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);

  state_t           st;
  logic             vppm_d;
  logic [CNT_W-1:0] per_q;
  logic [EW-1:0]    edge_cnt;
  logic [BW-1:0]    byte_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       next_byte;
  logic             edge_det;
  logic             sample;
  logic             timeout;
  logic             per_bad;
  logic             accept;

  assign edge_det     = vppm_in & ~vppm_d;
  assign next_byte    = {shreg[6:0], ~vppm_in};
  assign accept       = byte_valid & byte_ready;
  assign busy         = (st != IDLE);
  assign sample_point = sample;
  assign per_bad      =
    (period_cycles[CNT_W-1:0] < CNT_W'(MIN_PERIOD)) ||
    ((period_cycles >> CNT_W) != 32'd0);

  vppm_phase_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_SYMBOLS(TIMEOUT_SYMBOLS)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .per_q   (per_q),
    .edge_det(edge_det),
    .start   (st == SYNC && edge_det),
    .run     (st == SAMPLE),
    .tmr_en  (st == SYNC || st == SAMPLE),
    .sample  (sample),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      vppm_d     <= 1'b0;
      per_q      <= '0;
      edge_cnt   <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      vppm_d     <= vppm_in;
      frame_done <= 1'b0;
      if (!enable || st == IDLE) begin
        st         <= enable ? WAIT_FREQ : IDLE;
        byte_valid <= 1'b0;
        frame_err  <= 1'b0;
        edge_cnt   <= '0;
        byte_cnt   <= '0;
        bit_cnt    <= '0;
        shreg      <= '0;
      end else begin
        unique case (st)
          WAIT_FREQ: if (freq_valid) begin
            per_q <= period_cycles[CNT_W-1:0];
            if (per_bad) begin
              st        <= ERR;
              frame_err <= 1'b1;
            end else begin
              st <= HUNT;
            end
          end
          HUNT: if (edge_det) begin
            edge_cnt <= edge_cnt + EW'(1);
            if (edge_cnt == LAST_EDGE) st <= SYNC;
          end
          SYNC: begin
            if (edge_det) begin
              st      <= SAMPLE;
              bit_cnt <= '0;
            end else if (timeout) begin
              st        <= ERR;
              frame_err <= 1'b1;
            end
          end
          SAMPLE: begin
            if (timeout) begin
              st         <= ERR;
              frame_err  <= 1'b1;
              byte_valid <= 1'b0;
            end else begin
              if (accept) byte_valid <= 1'b0;
              if (sample) begin
                shreg   <= next_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (byte_valid && !byte_ready) begin
                    st         <= ERR;
                    frame_err  <= 1'b1;
                    byte_valid <= 1'b0;
                  end else begin
                    byte_data  <= next_byte;
                    byte_valid <= 1'b1;
                  end
                end
              end
              // Frame end wins over a byte landing in the same cycle.
              if (accept) begin
                if (byte_cnt == LAST_BYTE) begin
                  st         <= HUNT;
                  frame_done <= 1'b1;
                  byte_valid <= 1'b0;
                  byte_cnt   <= '0;
                  edge_cnt   <= '0;
                  bit_cnt    <= '0;
                end else begin
                  byte_cnt <= byte_cnt + BW'(1);
                end
              end
            end
          end
          ERR:     byte_valid <= 1'b0;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/vppm_rx_controller.md
Name: vppm_rx_controller

Overview:
Sequencer for the VPPM receive path. It waits for a valid carrier-period measurement and hunts the preamble edges. It then generates the per-symbol sample strobe, assembles bits into bytes, and hands bytes to the consumer with a valid/ready handshake. It sits between the frequency-measurement block and the byte-level framing/UART logic, and detects overrun, signal loss and invalid period.

Parameters:
PREAMBLE_EDGES, 7, vppm_in rising edges counted before the sync edge
FRAME_BYTES, 4, bytes per frame; frame_done pulses after the last one
CNT_W, 25, phase/timeout counter width
TIMEOUT_SYMBOLS, 8, symbol periods without a vppm_in rising edge before signal-loss error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  arm receiver; deassert returns to IDLE next cycle
vppm_in  in  1  VPPM line, already synchronised to clk
freq_valid  in  1  period_cycles is valid
period_cycles  in  32  symbol period in clk cycles
sample_point  out  1  1-cycle strobe at each bit sample
byte_data  out  8  assembled byte, MSB first
byte_valid  out  1  byte_data valid; held until byte_ready
byte_ready  in  1  consumer accepts byte
frame_done  out  1  1-cycle pulse when byte FRAME_BYTES-1 is accepted
frame_err  out  1  sticky error, cleared in IDLE
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, all counters 0.
- Edge detection: edge = vppm_in & ~vppm_in_d (one-cycle registered delay). vppm_in_d resets to 0.
- IDLE: clear frame_err and counters. Go to WAIT_FREQ when enable=1.
- WAIT_FREQ: when freq_valid=1, latch period_cycles[CNT_W-1:0] into per_q, then check it:
  - per_q < 4, or period_cycles[31:CNT_W] != 0 -> ERR.
  - otherwise -> HUNT.
- HUNT: count edges. When the count reaches PREAMBLE_EDGES -> SYNC.
- SYNC: the next edge sets phase=0 and enters SAMPLE in the same cycle.
- SAMPLE: phase increments each cycle and wraps per_q-1 -> 0.
  - When phase == per_q>>2: sample_point=1 for that cycle, bit = ~vppm_in is shifted into the shift register LSB.
  - After 8 bits, the byte is copied to byte_data in the same cycle and byte_valid is set.
- Handshake: a byte transfers in a cycle where byte_valid & byte_ready. byte_valid drops the next cycle unless a new byte loads in that same cycle.
- Overrun: an 8th bit completing while byte_valid=1 and byte_ready=0 -> frame_err=1, state ERR. The pending byte is dropped.
- Frame end: on acceptance of byte FRAME_BYTES-1, frame_done pulses and the state goes to HUNT. Edge and byte counters clear.
- Timeout: a timer runs in SYNC and SAMPLE and clears on every edge. Reaching TIMEOUT_SYMBOLS*per_q (computed in CNT_W+4 bits) -> frame_err=1, state ERR.
- ERR: busy=1, no strobes, byte_valid forced 0. Exit only via enable=0 -> IDLE.
- enable=0 in any state -> IDLE on the next clock. A pending byte_valid is cleared; no frame_done.
- rst mid-frame: everything returns to reset values on the next clock edge.
- Simultaneous byte acceptance and 8th-bit completion: no overrun; the new byte loads.
- per_q is frozen while busy; changes to period_cycles mid-frame are ignored.

Optional Feature:
VPPM_RESYNC_EN:
- Defined: in SAMPLE, an edge arriving while phase > per_q - (per_q>>3) or phase < (per_q>>3) forces phase=0 on the next cycle. This tracks clock drift and never produces a duplicate sample_point.
- Undefined: phase free-runs from the sync edge; edges only reset the timeout timer.

Decomposition:
- Package vppm_rx_pkg: the state enum (IDLE, WAIT_FREQ, HUNT, SYNC, SAMPLE, ERR), the CNT_W default and the minimum-period constant 4.
- Sub-module vppm_phase_timer holds the phase counter, the sample-strobe compare, the timeout timer and the optional resync logic. The FSM and byte assembly stay in the top module.

Test Plan:
- Nominal: period_cycles=40, freq_valid=1, 7 preamble edges + sync edge, 4 bytes A5,3C,FF,00, byte_ready=1 -> four byte_valid with those values, sample_point every 40 cycles at phase 10, frame_done once.
- Backpressure: byte_ready=0 for 30 cycles after the first byte -> byte_valid held with A5 stable. Hold byte_ready=0 until the 2nd byte completes -> frame_err=1, state ERR, byte_valid=0.
- Invalid period: period_cycles=3 -> ERR one cycle after freq_valid, busy=1, no sample_point.
- Signal loss: line held low after 2 bytes with per_q=40 -> frame_err after 320 cycles without an edge.
- Abort: enable=0 mid-byte, then enable=1 -> busy=0 for one cycle, frame_err clear, the new frame decodes correctly.
- Resync (macro defined): edges drift +2 cycles per symbol over 16 symbols -> every bit decoded correctly. Macro undefined -> a bit error is expected after about 5 symbols.
